// File: rtl/elevador_pkg.sv
// elevador_pkg: shared types and helpers for the N-floor elevator controller.
//   state_t      controller states
//   SEG_*        7-segment patterns {g,f,e,d,c,b,a}, active-high
//   onehot_idx   index of the lowest set bit of a (one-hot) vector
//   multi_hot    high when more than one bit of a vector is set
//   seg_digit    segment pattern for a decimal digit 1..9
package elevador_pkg;

  typedef enum logic [2:0] {
    HOMING,
    IDLE,
    UP,
    DOWN,
    DOOR,
    FAULT
  } state_t;

  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Lowest set bit wins, so a vector with several bits set still yields a
  // defined index; callers that care reject that case with multi_hot.
  function automatic logic [3:0] onehot_idx(input logic [8:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 8; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_hot(input logic [8:0] v);
    return (v & (v - 9'd1)) != 9'd0;
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/elevador_npisos_if.sv
// elevador_npisos_if: car/hall side bundle of the elevator controller.
//   call, sensor             building -> controller (buttons, floor sensors)
//   display, mup, mdw,       controller -> building (7-seg, motor, door,
//   door_open, pending,      latched requests, fault flag)
//   fault
// master = building side, slave = controller.
interface elevador_npisos_if #(
  parameter int FLOORS = 3
);
  logic [FLOORS-1:0] call;
  logic [FLOORS-1:0] sensor;
  logic [6:0]        display;
  logic              mup;
  logic              mdw;
  logic              door_open;
  logic [FLOORS-1:0] pending;
  logic              fault;

  modport master (
    output call, sensor,
    input  display, mup, mdw, door_open, pending, fault
  );

  modport slave (
    input  call, sensor,
    output display, mup, mdw, door_open, pending, fault
  );
endinterface

// File: rtl/elevador_seg7.sv
// elevador_seg7: combinational floor display decoder.
//   floor_idx  in   0-based floor index
//   fault      in   show "E" instead of the floor
//   blank      in   display off (car not yet homed)
//   display    out  segments {g,f,e,d,c,b,a}, active-high
module elevador_seg7
  import elevador_pkg::*;
#(
  parameter int FW = 2
) (
  input  logic [FW-1:0] floor_idx,
  input  logic          fault,
  input  logic          blank,
  output logic [6:0]    display
);

  logic [3:0] digit;

  // Floors are shown 1-based.
  assign digit = 4'(floor_idx) + 4'd1;

  always_comb begin
    display = seg_digit(digit);
    if (blank) begin
      display = SEG_BLANK;
    end else if (fault) begin
      display = SEG_E;
    end
  end

endmodule

// File: rtl/elevador_npisos.sv
// elevador_npisos: N-floor collective (SCAN) elevator controller.
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-low
//   bus    slave side of elevador_npisos_if: call/sensor in; display, mup,
//          mdw, door_open, pending, fault out (all but display registered)
// Homes downwards after reset, latches calls, keeps the travel direction
// while requests lie ahead, dwells DOOR_CYCLES at each stop and locks into
// FAULT on a travel timeout or an inconsistent sensor pattern.
module elevador_npisos
  import elevador_pkg::*;
#(
  parameter int FLOORS         = 3,
  parameter int DOOR_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  elevador_npisos_if.slave   bus
);

  localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(FLOORS - 1);
  localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES - 1);
  localparam logic [WW-1:0] WD_LIMIT  = WW'(TIMEOUT_CYCLES);

  state_t            state_reg, state_next;
  logic [FW-1:0]     floor_reg, floor_next;
  logic              dir_reg, dir_next;          // 1 = up
  logic [FLOORS-1:0] pending_reg, pending_next;
  logic              mup_reg, mup_next;
  logic              mdw_reg, mdw_next;
  logic              door_reg, door_next;
  logic              fault_reg, fault_next;
  logic [DW-1:0]     door_cnt_reg, door_cnt_next;
  logic [WW-1:0]     wd_cnt_reg, wd_cnt_next;

  // Floor-relative masks of the current floor register.
  logic [FLOORS-1:0] here_mask, above_mask, below_mask;

  genvar gi;
  generate
    for (gi = 0; gi < FLOORS; gi++) begin : g_mask
      assign here_mask[gi]  = (FW'(gi) == floor_reg);
      assign above_mask[gi] = (FW'(gi) >  floor_reg);
      assign below_mask[gi] = (FW'(gi) <  floor_reg);
    end
  endgenerate

  logic [8:0]        sensor_ext;
  logic [FW-1:0]     sensor_idx;
  logic              sensor_any, sensor_multi, new_floor, at_end, stop_hit;
  logic              here_call, above_any, below_any, go_up, go_dn;
  logic [FLOORS-1:0] pend_all, pend_masked;
  state_t            dec_state;
  logic              dec_dir;

  assign sensor_ext   = 9'(bus.sensor);
  assign sensor_idx   = FW'(onehot_idx(sensor_ext));
  assign sensor_any   = |bus.sensor;
  assign sensor_multi = multi_hot(sensor_ext);
  assign new_floor    = sensor_any && (sensor_idx != floor_reg);
  assign at_end       = (state_reg == UP) ? (sensor_idx == TOP_FLOOR)
                                          : (sensor_idx == '0);

  // While moving every call is latched; while parked a call for the current
  // floor opens the door instead of becoming a request.
  assign pend_all    = pending_reg | bus.call;
  assign pend_masked = pending_reg | (bus.call & ~here_mask);
  assign here_call   = |(bus.call & here_mask);
  // sensor is one-hot whenever this is used (multi-hot faults first).
  assign stop_hit    = |(pend_all & bus.sensor);

  // Direction decision shared by IDLE and door expiry: keep the current
  // direction while requests lie ahead, otherwise reverse if any lie behind.
  assign above_any = |(pend_masked & above_mask);
  assign below_any = |(pend_masked & below_mask);
  assign go_up     = dir_reg ? above_any : (!below_any && above_any);
  assign go_dn     = dir_reg ? (!above_any && below_any) : below_any;
  assign dec_state = go_up ? UP : (go_dn ? DOWN : IDLE);
  assign dec_dir   = go_up ? 1'b1 : (go_dn ? 1'b0 : dir_reg);

  always_comb begin
    state_next    = state_reg;
    floor_next    = floor_reg;
    dir_next      = dir_reg;
    pending_next  = pending_reg;
    mup_next      = mup_reg;
    mdw_next      = mdw_reg;
    door_next     = door_reg;
    fault_next    = fault_reg;
    door_cnt_next = door_cnt_reg;
    wd_cnt_next   = wd_cnt_reg;

    case (state_reg)
      HOMING: begin
        if (sensor_any) begin
          floor_next = sensor_idx;
          mdw_next   = 1'b0;
          state_next = IDLE;
        end else begin
          mdw_next = 1'b1;
        end
      end

      IDLE: begin
        pending_next = pend_masked;
        if (here_call) begin
          door_next     = 1'b1;
          door_cnt_next = DOOR_LOAD;
          state_next    = DOOR;
        end else begin
          state_next  = dec_state;
          dir_next    = dec_dir;
          mup_next    = go_up;
          mdw_next    = go_dn;
          wd_cnt_next = '0;
        end
      end

      DOOR: begin
        pending_next = pend_masked;
        if (here_call) begin
          door_cnt_next = DOOR_LOAD;
        end else if (door_cnt_reg == '0) begin
          door_next   = 1'b0;
          state_next  = dec_state;
          dir_next    = dec_dir;
          mup_next    = go_up;
          mdw_next    = go_dn;
          wd_cnt_next = '0;
        end else begin
          door_cnt_next = door_cnt_reg - DW'(1);
        end
      end

      UP, DOWN: begin
        pending_next = pend_all;
        if (sensor_multi) begin
          state_next = FAULT;
          mup_next   = 1'b0;
          mdw_next   = 1'b0;
          fault_next = 1'b1;
        end else if (new_floor) begin
          floor_next  = sensor_idx;
          wd_cnt_next = '0;
          if (stop_hit || at_end) begin
            pending_next  = pend_all & ~bus.sensor;
            mup_next      = 1'b0;
            mdw_next      = 1'b0;
            door_next     = 1'b1;
            door_cnt_next = DOOR_LOAD;
            state_next    = DOOR;
          end
        end else if (wd_cnt_reg + WW'(1) == WD_LIMIT) begin
          state_next = FAULT;
          mup_next   = 1'b0;
          mdw_next   = 1'b0;
          fault_next = 1'b1;
        end else begin
          wd_cnt_next = wd_cnt_reg + WW'(1);
        end
      end

      FAULT: begin
        mup_next   = 1'b0;
        mdw_next   = 1'b0;
        door_next  = 1'b0;
        fault_next = 1'b1;
      end

      default: state_next = HOMING;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= HOMING;
      floor_reg    <= '0;
      dir_reg      <= 1'b1;
      pending_reg  <= '0;
      mup_reg      <= 1'b0;
      mdw_reg      <= 1'b0;
      door_reg     <= 1'b0;
      fault_reg    <= 1'b0;
      door_cnt_reg <= '0;
      wd_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      floor_reg    <= floor_next;
      dir_reg      <= dir_next;
      pending_reg  <= pending_next;
      mup_reg      <= mup_next;
      mdw_reg      <= mdw_next;
      door_reg     <= door_next;
      fault_reg    <= fault_next;
      door_cnt_reg <= door_cnt_next;
      wd_cnt_reg   <= wd_cnt_next;
    end
  end

  assign bus.mup       = mup_reg;
  assign bus.mdw       = mdw_reg;
  assign bus.door_open = door_reg;
  assign bus.pending   = pending_reg;
  assign bus.fault     = fault_reg;

  elevador_seg7 #(
    .FW (FW)
  ) u_seg7 (
    .floor_idx (floor_reg),
    .fault     (fault_reg),
    .blank     (state_reg == HOMING),
    .display   (bus.display)
  );

endmodule
